// File: rtl/bus_poll_scheduler_pkg.sv
// Shared definitions for the RS485 motor poll scheduler and its frame engine.
package bus_poll_scheduler_pkg;

    // Frame types requested from the frame engine
    typedef enum logic [1:0] {
        STATUS_REQ   = 2'd0,
        COMMAND      = 2'd1,
        CONTROL_MODE = 2'd2
    } frame_type_e;

    // Scheduler states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_SLOT = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } sched_state_e;

    // Frame magic numbers, kept here so the frame engine and scheduler agree
    localparam logic [7:0] FRAME_SOF           = 8'hA5;
    localparam logic [7:0] FRAME_MAGIC_STATUS  = 8'h3C;
    localparam logic [7:0] FRAME_MAGIC_COMMAND = 8'h5A;
    localparam logic [7:0] FRAME_MAGIC_CTRL    = 8'h69;

endpackage

// File: rtl/bus_poll_scheduler_rr.sv
// Round-robin search: first set bit of mask strictly after cur_idx, wrapping.
// If cur_idx is the only enabled motor it is selected again.
module rr_next_index #(
    parameter int N = 10
) (
    input  logic [N-1:0] mask,
    input  logic [7:0]   cur_idx,
    output logic [7:0]   next_idx,
    output logic         found
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [8:0]     sum;

    // Rotate the mask so bit j stands for motor cur_idx+1+j, then take the lowest set bit
    always_comb begin
        dbl      = {mask, mask};
        rot      = N'(dbl >> ({1'b0, cur_idx} + 9'd1));
        found    = 1'b0;
        sum      = '0;
        next_idx = cur_idx;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                sum   = {1'b0, cur_idx} + 9'd1 + 9'(j);
            end
        end
        if (sum >= 9'(N)) begin
            sum = sum - 9'(N);
        end
        if (found) begin
            next_idx = 8'(sum);
        end
    end

endmodule

// File: rtl/bus_poll_scheduler.sv
// Schedules status polls, control-mode and command frames for motors sharing
// one RS485 bus, with response timeout, bus guard gap and per-motor statistics.
module bus_poll_scheduler
    import bus_poll_scheduler_pkg::*;
#(
    parameter int NUMBER_OF_MOTORS = 10,
    parameter int CNT_W            = 16
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   enable,
    input  logic [NUMBER_OF_MOTORS-1:0]            motor_enable,
    input  logic [31:0]                            slot_cycles,
    input  logic [31:0]                            timeout_cycles,
    input  logic [15:0]                            guard_cycles,
    input  logic [NUMBER_OF_MOTORS-1:0]            ctrl_update_req,
    input  logic [NUMBER_OF_MOTORS-1:0]            setpoint_update_req,
    output logic                                   cmd_valid,
    input  logic                                   cmd_ready,
    output logic [7:0]                             cmd_motor,
    output logic [1:0]                             cmd_type,
    input  logic                                   txn_done,
    input  logic                                   txn_ok,
    output logic                                   rsp_timeout,
    output logic                                   busy,
    input  logic                                   counters_clear,
    output logic [NUMBER_OF_MOTORS-1:0][CNT_W-1:0] req_count,
    output logic [NUMBER_OF_MOTORS-1:0][CNT_W-1:0] ok_count
);

    localparam int         N        = NUMBER_OF_MOTORS;
    localparam logic [7:0] LAST_IDX = 8'(N - 1);

    sched_state_e state_q, state_d;
    frame_type_e  type_q, type_d;
    logic [7:0]   motor_q, motor_d;
    logic [31:0]  slot_tmr_q;
    logic [31:0]  rsp_tmr_q;
    logic [15:0]  gap_tmr_q;
    logic [N-1:0] ctrl_pend_q;
    logic [N-1:0] setp_pend_q;
    logic         poll_ok_q;
    logic         rsp_timeout_q;

    logic [7:0]   rr_next;
    logic         rr_found;
    logic [N-1:0] motor_oh;
    logic         handshake;
    logic         hs_status;
    logic         hs_ctrl;
    logic         hs_command;
    logic         poll_done_ok;
    logic         expire;
    logic         gap_enter;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    rr_next_index #(
        .N (N)
    ) u_rr (
        .mask     (motor_enable),
        .cur_idx  (motor_q),
        .next_idx (rr_next),
        .found    (rr_found)
    );

    // Decode the current motor and this cycle's handshake / completion events
    always_comb begin
        motor_oh = '0;
        for (int i = 0; i < N; i++) begin
            motor_oh[i] = (motor_q == 8'(i));
        end
        handshake    = (state_q == ISSUE) && cmd_ready;
        hs_status    = handshake && (type_q == STATUS_REQ);
        hs_ctrl      = handshake && (type_q == CONTROL_MODE);
        hs_command   = handshake && (type_q == COMMAND);
        poll_done_ok = (state_q == WAIT_DONE) && txn_done && txn_ok && (type_q == STATUS_REQ);
    end

    // Next-state logic; WAIT_SLOT leaves two cycles early so a ready engine
    // handshakes on the very edge where the slot timer runs out
    always_comb begin
        state_d   = state_q;
        motor_d   = motor_q;
        type_d    = type_q;
        expire    = 1'b0;
        gap_enter = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && (|motor_enable)) begin
                    state_d = WAIT_SLOT;
                end
            end
            WAIT_SLOT: begin
                if (!enable || !rr_found) begin
                    state_d = IDLE;
                end else if (slot_tmr_q <= 32'd2) begin
                    state_d = ISSUE;
                    motor_d = rr_next;
                    type_d  = STATUS_REQ;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // txn_done wins over a same-cycle expiry
                if (txn_done) begin
                    state_d   = GAP;
                    gap_enter = 1'b1;
                end else if (rsp_tmr_q <= 32'd1) begin
                    state_d   = GAP;
                    gap_enter = 1'b1;
                    expire    = 1'b1;
                end
            end
            GAP: begin
                if (gap_tmr_q <= 16'd1) begin
                    if (poll_ok_q && (|(ctrl_pend_q & motor_oh))) begin
                        state_d = ISSUE;
                        type_d  = CONTROL_MODE;
                    end else if (poll_ok_q && (|(setp_pend_q & motor_oh))) begin
                        state_d = ISSUE;
                        type_d  = COMMAND;
                    end else if (enable && (|motor_enable)) begin
                        state_d = WAIT_SLOT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, current frame, timers and the follow-up qualifier
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            motor_q       <= LAST_IDX;
            type_q        <= STATUS_REQ;
            slot_tmr_q    <= '0;
            rsp_tmr_q     <= '0;
            gap_tmr_q     <= '0;
            poll_ok_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            motor_q       <= motor_d;
            type_q        <= type_d;
            rsp_timeout_q <= expire;
            if (hs_status) begin
                slot_tmr_q <= slot_cycles;
            end else if (slot_tmr_q != 32'd0) begin
                slot_tmr_q <= slot_tmr_q - 32'd1;
            end
            if (handshake) begin
                rsp_tmr_q <= timeout_cycles;
            end else if (rsp_tmr_q != 32'd0) begin
                rsp_tmr_q <= rsp_tmr_q - 32'd1;
            end
            if (gap_enter) begin
                gap_tmr_q <= guard_cycles;
            end else if (gap_tmr_q != 16'd0) begin
                gap_tmr_q <= gap_tmr_q - 16'd1;
            end
            // Only a successful status poll unlocks follow-up frames
            if (gap_enter) begin
                poll_ok_q <= poll_done_ok;
            end
        end
    end

    // Sticky pending flags; a same-cycle request pulse beats the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_pend_q <= '0;
            setp_pend_q <= '0;
        end else begin
            ctrl_pend_q <= (ctrl_pend_q & ~(motor_oh & {N{hs_ctrl}})) | ctrl_update_req;
            // The control-mode frame also carries the setpoint
            setp_pend_q <= (setp_pend_q & ~(motor_oh & {N{hs_ctrl | hs_command}})) | setpoint_update_req;
        end
    end

    // Per-motor saturating statistics; clear beats any same-cycle increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_count <= '0;
            ok_count  <= '0;
        end else if (counters_clear) begin
            req_count <= '0;
            ok_count  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (hs_status && motor_oh[i]) begin
                    req_count[i] <= sat_inc(req_count[i]);
                end
                if (poll_done_ok && motor_oh[i]) begin
                    ok_count[i] <= sat_inc(ok_count[i]);
                end
            end
        end
    end

    assign cmd_valid   = (state_q == ISSUE);
    assign cmd_motor   = motor_q;
    assign cmd_type    = type_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_bus_poll_scheduler.sv
// Directed bench for bus_poll_scheduler with a simple frame-engine responder.
module tb_bus_poll_scheduler;

    localparam int N  = 4;
    localparam int CW = 2;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    enable;
    logic [N-1:0]            motor_enable;
    logic [31:0]             slot_cycles;
    logic [31:0]             timeout_cycles;
    logic [15:0]             guard_cycles;
    logic [N-1:0]            ctrl_update_req;
    logic [N-1:0]            setpoint_update_req;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [7:0]              cmd_motor;
    logic [1:0]              cmd_type;
    logic                    txn_done;
    logic                    txn_ok;
    logic                    rsp_timeout;
    logic                    busy;
    logic                    counters_clear;
    logic [N-1:0][CW-1:0]    req_count;
    logic [N-1:0][CW-1:0]    ok_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hs_motor[$];
    int hs_type[$];
    int hs_edge[$];
    int to_cnt  = 0;
    int to_edge = 0;

    logic resp_en    = 1'b0;
    int   resp_delay = 20;
    logic resp_ok    = 1'b1;

    typedef struct {
        logic [N-1:0] mask;
        int           exp_m[5];
        int           exp_req0;
    } poll_vec_t;

    poll_vec_t vecs[4];

    bus_poll_scheduler #(
        .NUMBER_OF_MOTORS (N),
        .CNT_W            (CW)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .enable              (enable),
        .motor_enable        (motor_enable),
        .slot_cycles         (slot_cycles),
        .timeout_cycles      (timeout_cycles),
        .guard_cycles        (guard_cycles),
        .ctrl_update_req     (ctrl_update_req),
        .setpoint_update_req (setpoint_update_req),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_motor           (cmd_motor),
        .cmd_type            (cmd_type),
        .txn_done            (txn_done),
        .txn_ok              (txn_ok),
        .rsp_timeout         (rsp_timeout),
        .busy                (busy),
        .counters_clear      (counters_clear),
        .req_count           (req_count),
        .ok_count            (ok_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log handshakes (with the edge they complete on) and timeout pulses
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            hs_motor.push_back(int'(cmd_motor));
            hs_type.push_back(int'(cmd_type));
            hs_edge.push_back(cyc + 1);
        end
        if (rsp_timeout) begin
            to_cnt  <= to_cnt + 1;
            to_edge <= cyc;
        end
    end

    // Frame engine model: txn_done is sampled resp_delay edges after the handshake
    initial begin
        txn_done = 1'b0;
        txn_ok   = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && cmd_valid && cmd_ready && reset_n) begin
                repeat (resp_delay) @(negedge clk);
                txn_done = 1'b1;
                txn_ok   = resp_ok;
                @(negedge clk);
                txn_done = 1'b0;
                txn_ok   = 1'b0;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n             = 1'b0;
        enable              = 1'b0;
        motor_enable        = '0;
        slot_cycles         = 32'd100;
        timeout_cycles      = 32'd50;
        guard_cycles        = 16'd4;
        ctrl_update_req     = '0;
        setpoint_update_req = '0;
        cmd_ready           = 1'b1;
        counters_clear      = 1'b0;
        resp_en             = 1'b0;
        resp_delay          = 20;
        resp_ok             = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_hs(input int target, input int limit, input string name);
        int n = 0;
        while (hs_motor.size() < target && n < limit) begin
            tick(1);
            n++;
        end
        check(name, hs_motor.size(), target);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while (busy && n < limit) begin
            tick(1);
            n++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        int base;
        int to0;
        int n;

        vecs[0] = '{4'b1111, '{0, 1, 2, 3, 0}, 2};
        vecs[1] = '{4'b0101, '{0, 2, 0, 2, 0}, 3};
        vecs[2] = '{4'b1000, '{3, 3, 3, 3, 3}, 0};
        vecs[3] = '{4'b0110, '{1, 2, 1, 2, 1}, 0};

        // Reset state
        do_reset();
        check("rst cmd_valid", cmd_valid, 0);
        check("rst cmd_motor", cmd_motor, N - 1);
        check("rst cmd_type", cmd_type, 0);
        check("rst busy", busy, 0);
        check("rst rsp_timeout", rsp_timeout, 0);
        check("rst req_count", req_count, 0);
        check("rst ok_count", ok_count, 0);

        // Empty mask keeps the scheduler idle
        enable = 1'b1;
        tick(10);
        check("zero mask busy", busy, 0);
        check("zero mask cmd_valid", cmd_valid, 0);

        // Round-robin poll order and slot spacing
        for (int v = 0; v < 4; v++) begin
            do_reset();
            base         = hs_motor.size();
            motor_enable = vecs[v].mask;
            resp_en      = 1'b1;
            enable       = 1'b1;
            wait_hs(base + 5, 700, $sformatf("row%0d poll count", v));
            tick(1);
            for (int k = 0; k < 5; k++) begin
                check($sformatf("row%0d poll%0d motor", v, k), hs_motor[base+k], vecs[v].exp_m[k]);
                check($sformatf("row%0d poll%0d type", v, k), hs_type[base+k], 0);
                if (k > 0) begin
                    check($sformatf("row%0d poll%0d spacing", v, k),
                          hs_edge[base+k] - hs_edge[base+k-1], 100);
                end
            end
            check($sformatf("row%0d req_count0", v), req_count[0], vecs[v].exp_req0);
            enable = 1'b0;
            wait_idle(200, $sformatf("row%0d stops idle", v));
        end

        // Control-mode frame supersedes the pending setpoint
        do_reset();
        motor_enable        = 4'b0010;
        resp_en             = 1'b1;
        ctrl_update_req     = 4'b0010;
        setpoint_update_req = 4'b0010;
        tick(1);
        ctrl_update_req     = '0;
        setpoint_update_req = '0;
        base   = hs_motor.size();
        enable = 1'b1;
        wait_hs(base + 1, 50, "ctrl first poll");
        tick(90);
        check("ctrl frame count", hs_motor.size(), base + 2);
        check("ctrl frame motor", hs_motor[base+1], 1);
        check("ctrl frame type", hs_type[base+1], 2);
        check("ctrl pend cleared", dut.ctrl_pend_q, 0);
        check("setp pend cleared", dut.setp_pend_q, 0);
        // A lone setpoint request produces a command frame after the next poll
        setpoint_update_req = 4'b0010;
        tick(1);
        setpoint_update_req = '0;
        tick(40);
        check("cmd frame count", hs_motor.size(), base + 4);
        check("cmd poll type", hs_type[base+2], 0);
        check("cmd frame type", hs_type[base+3], 1);
        check("cmd frame motor", hs_motor[base+3], 1);
        check("cmd setp cleared", dut.setp_pend_q, 0);
        enable = 1'b0;
        wait_idle(200, "ctrl stops idle");

        // Response timeout skips the pending command frame
        do_reset();
        motor_enable        = 4'b0001;
        setpoint_update_req = 4'b0001;
        tick(1);
        setpoint_update_req = '0;
        base   = hs_motor.size();
        to0    = to_cnt;
        enable = 1'b1;
        wait_hs(base + 1, 50, "timeout first poll");
        n = 0;
        while (to_cnt == to0 && n < 100) begin
            tick(1);
            n++;
        end
        check("timeout pulse seen", to_cnt - to0, 1);
        check("timeout delay", to_edge - hs_edge[base], 50);
        tick(60);
        check("timeout pulse width", to_cnt - to0, 1);
        check("timeout frame count", hs_motor.size(), base + 2);
        check("timeout next type", hs_type[base+1], 0);
        check("timeout ok_count", ok_count[0], 0);
        check("timeout setp kept", dut.setp_pend_q[0], 1);
        enable = 1'b0;
        wait_idle(200, "timeout stops idle");

        // txn_done on the expiry edge wins; then counter saturation and clear
        do_reset();
        motor_enable = 4'b0001;
        resp_en      = 1'b1;
        resp_delay   = 50;
        base         = hs_motor.size();
        to0          = to_cnt;
        enable       = 1'b1;
        wait_hs(base + 1, 50, "tie first poll");
        tick(60);
        check("tie no timeout", to_cnt - to0, 0);
        check("tie ok_count", ok_count[0], 1);
        check("tie req_count", req_count[0], 1);
        tick(450);
        check("sat req_count", req_count[0], 3);
        check("sat ok_count", ok_count[0], 3);
        check("sat no timeout", to_cnt - to0, 0);
        counters_clear = 1'b1;
        tick(1);
        counters_clear = 1'b0;
        check("clear req_count", req_count[0], 0);
        check("clear ok_count", ok_count[0], 0);
        enable = 1'b0;
        wait_idle(200, "tie stops idle");

        // Asynchronous reset in the middle of WAIT_DONE
        do_reset();
        motor_enable   = 4'b1111;
        timeout_cycles = 32'd1000;
        base           = hs_motor.size();
        enable         = 1'b1;
        wait_hs(base + 1, 50, "areset first poll");
        cmd_ready = 1'b0;
        tick(5);
        check("areset pre busy", busy, 1);
        check("areset pre motor", cmd_motor, 0);
        check("areset pre req_count", req_count[0], 1);
        #2 reset_n = 1'b0;
        #1;
        check("areset cmd_valid", cmd_valid, 0);
        check("areset busy", busy, 0);
        check("areset cmd_motor", cmd_motor, N - 1);
        check("areset cmd_type", cmd_type, 0);
        check("areset req_count", req_count[0], 0);
        check("areset rsp_timeout", rsp_timeout, 0);
        tick(2);
        reset_n = 1'b1;
        n = 0;
        while (!cmd_valid && n < 20) begin
            tick(1);
            n++;
        end
        check("post reset cmd_valid", cmd_valid, 1);
        check("post reset motor", cmd_motor, 0);
        check("post reset type", cmd_type, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
